// File: rtl/types_pkg.sv
// ---------------------------------------------------------------------------
// types_pkg
//
// Shared types and constants for the core's data-store path.
//
// Core-wide types:
//   ADDR_WIDTH   width of DataAdr
//   word_t       32-bit data word carried by WriteData / ReadData
//
// UART transmitter (mmio_uart_tx):
//   UART_TXDATA / UART_STATUS / UART_BAUD   register index (DataAdr[3:2])
//   STAT_*                                  bit positions in STATUS
//   uart_state_t                            serialiser FSM states
//   bit_reload()                            bit-timer reload for a divisor
// ---------------------------------------------------------------------------
package types_pkg;

   localparam int ADDR_WIDTH = 32;
   typedef logic [31:0] word_t;

   // Register index taken from data_address[3:2]
   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_BAUD   = 2'd2;

   // STATUS layout
   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVF       = 3;
   localparam int STAT_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // The bit timer counts down to zero, so a bit lasts reload+1 cycles.
   // A divisor of 0 behaves like 1 so a frame always advances.
   function automatic logic [15:0] bit_reload(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : div - 16'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with show-ahead read data: rdata always presents the
// oldest entry, and pop simply advances past it.
//
// Ports:
//   clk     system clock
//   reset   synchronous reset, active low (flushes the FIFO)
//   push    write wdata; accepted when not full, or when a pop happens in
//           the same cycle
//   wdata   data to write
//   pop     discard the head entry; ignored when empty
//   rdata   head entry (valid when empty==0)
//   full    count == DEPTH
//   empty   count == 0
//   count   number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Show-ahead needs an asynchronous read of the head slot, so the storage
   // is a small register array rather than a synchronous-read RAM.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg,  count_next;
   logic             do_push;
   logic             do_pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign count = count_reg;
   assign rdata = mem[rd_ptr_reg];

   // A pop frees a slot in the same cycle, so a push into a full FIFO
   // still succeeds when it coincides with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
      // natural overflow of the increment is the modulo-DEPTH wrap.
      if (do_push) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage contents need no reset: count and pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter on the core's data-store path. Stores to
// TXDATA are queued in a FIFO and sent as 8N1 frames (start bit, 8 data bits
// LSB first, stop bit) on tx, so the core never waits for the serial line.
//
// Register map (data_address[3:2]):
//   0 TXDATA   write: push write_data[7:0]          read: 0
//   1 STATUS   read: [0] full [1] empty [2] busy [3] overflow (sticky)
//                    [11:8] FIFO count
//              write: bit3=1 clears overflow
//   2 BAUDDIV  r/w [15:0] clock cycles per bit (0 acts as 1)
//   3          reserved, reads 0, writes ignored
//
// Ports:
//   clk           system clock
//   reset         synchronous reset, active low
//   sel           chip select from the address decoder
//   write_enable  store strobe, effective only with sel
//   data_address  byte address, bits [3:2] select the register
//   write_data    store data
//   read_data     combinational register read data (0 when sel=0)
//   tx            serial output, idle high, driven from a flop
//   irq_empty     FIFO empty and serialiser idle
// ---------------------------------------------------------------------------
module mmio_uart_tx
   import types_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] RESET_DIV  = 16'd434
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sel,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] data_address,
   input  word_t                 write_data,
   output word_t                 read_data,
   output logic                  tx,
   output logic                  irq_empty
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic [1:0] reg_idx;
   logic       bus_wr;
   logic       txdata_wr;
   logic       status_wr;
   logic       baud_wr;

   assign reg_idx   = data_address[3:2];
   assign bus_wr    = sel && write_enable;
   assign txdata_wr = bus_wr && (reg_idx == UART_TXDATA);
   assign status_wr = bus_wr && (reg_idx == UART_STATUS);
   assign baud_wr   = bus_wr && (reg_idx == UART_BAUD);

   // Address bits outside [3:2] and the upper store-data half carry no
   // meaning for this block.
   logic unused_bits;
   assign unused_bits = ^{data_address[ADDR_WIDTH-1:4], data_address[1:0],
                          write_data[31:16]};

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic             pop;
   logic [7:0]       fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (txdata_wr),
      .wdata (write_data[7:0]),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   logic [15:0] baud_reg, baud_next;
   logic        overflow_reg, overflow_next;
   logic        overflow_set;

   // A push into a full FIFO is lost unless the serialiser pops that cycle.
   assign overflow_set = txdata_wr && fifo_full && !pop;

   always_comb begin
      baud_next = baud_reg;
      if (baud_wr) begin
         baud_next = write_data[15:0];
      end
   end

   // A new overflow wins over a clear in the same cycle so no drop is
   // ever hidden from software.
   always_comb begin
      overflow_next = overflow_reg;
      if (status_wr && write_data[STAT_OVF]) begin
         overflow_next = 1'b0;
      end
      if (overflow_set) begin
         overflow_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         baud_reg     <= RESET_DIV;
         overflow_reg <= 1'b0;
      end else begin
         baud_reg     <= baud_next;
         overflow_reg <= overflow_next;
      end
   end

   // ------------------------------------------------------------------
   // Serialiser FSM
   // ------------------------------------------------------------------
   uart_state_t state_reg, state_next;

   logic [15:0] timer_reg,   timer_next;    // cycles left in the current bit
   logic [15:0] div_reg,     div_next;      // divisor latched for this frame
   logic [7:0]  shift_reg,   shift_next;
   logic [2:0]  bit_idx_reg, bit_idx_next;
   logic        tx_reg,      tx_next;
   logic        bit_done;

   assign bit_done = (timer_reg == 16'd0);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = START;
            end
         end
         START: begin
            if (bit_done) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_done && (bit_idx_reg == 3'd7)) begin
               state_next = STOP;
            end
         end
         STOP: begin
            // Chain straight into the next start bit when more data waits.
            if (bit_done) begin
               state_next = fifo_empty ? IDLE : START;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      pop          = 1'b0;
      timer_next   = timer_reg;
      div_next     = div_reg;
      shift_next   = shift_reg;
      bit_idx_next = bit_idx_reg;
      tx_next      = 1'b1;

      case (state_reg)
         IDLE:    pop = !fifo_empty;
         STOP:    pop = bit_done && !fifo_empty;
         default: pop = 1'b0;
      endcase

      if (pop) begin
         // The divisor is captured here so BAUDDIV writes during a frame
         // only take effect from the next frame.
         shift_next   = fifo_head;
         div_next     = baud_reg;
         timer_next   = bit_reload(baud_reg);
         bit_idx_next = 3'd0;
      end else if (state_reg != IDLE) begin
         timer_next = bit_done ? bit_reload(div_reg) : timer_reg - 16'd1;
         if ((state_reg == DATA) && bit_done) begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
         end
      end

      // tx is registered from the state being entered, so the line changes
      // on the same edge as the state and never glitches.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         timer_reg   <= 16'd0;
         div_reg     <= 16'd0;
         shift_reg   <= 8'd0;
         bit_idx_reg <= 3'd0;
         tx_reg      <= 1'b1;
      end else begin
         timer_reg   <= timer_next;
         div_reg     <= div_next;
         shift_reg   <= shift_next;
         bit_idx_reg <= bit_idx_next;
         tx_reg      <= tx_next;
      end
   end

   assign tx        = tx_reg;
   assign irq_empty = fifo_empty && (state_reg == IDLE);

   // ------------------------------------------------------------------
   // Read mux (no side effects)
   // ------------------------------------------------------------------
   always_comb begin
      read_data = '0;
      if (sel) begin
         case (reg_idx)
            UART_STATUS: begin
               read_data[STAT_FULL]                    = fifo_full;
               read_data[STAT_EMPTY]                   = fifo_empty;
               read_data[STAT_BUSY]                    = (state_reg != IDLE);
               read_data[STAT_OVF]                     = overflow_reg;
               read_data[STAT_COUNT_LSB +: CNT_W]      = fifo_count;
            end
            UART_BAUD: read_data[15:0] = baud_reg;
            default:   read_data = '0;
         endcase
      end
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmit peripheral on the core's data-store path, beside data memory.
- The top-level address decoder drives its chip select from the same DataAdr/WriteData/MemWrite signals that feed data_mem.
- Buffers stored bytes in a small FIFO and serialises each one as an 8N1 frame on a tx pin.
- Gives the single-cycle core program-visible console output without stalling it.

Parameters:
- FIFO_DEPTH, 8, number of byte entries (power of two, >=2).
- RESET_DIV, 16'd434, reset value of BAUDDIV (50 MHz / 115200).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous reset, active-low (reset==0 clears state at the next rising clk edge).
- sel  in  1  chip select from the top-level address decoder.
- write_enable  in  1  store strobe (MemWrite); effective only when sel=1.
- data_address  in  ADDR_WIDTH  byte address; bits [3:2] select the register.
- write_data  in  32  store data.
- read_data  out  32  register read data, combinational.
- tx  out  1  serial output, idle high.
- irq_empty  out  1  high when the FIFO is empty and the FSM is IDLE.

Behaviour:
- Register map, by data_address[3:2]:
  - 0 TXDATA: write pushes write_data[7:0]; reads 0.
  - 1 STATUS: read bit0=full, bit1=empty, bit2=busy (FSM!=IDLE), bit3=overflow (sticky), bits[11:8]=FIFO count; write with bit3=1 clears overflow.
  - 2 BAUDDIV: r/w bits [15:0]; upper bits read 0.
  - 3: reserved; reads 0, writes ignored.
- read_data = 0 when sel=0. No read side effects.
- Reset values:
  - tx=1, FIFO empty, count=0, overflow=0, BAUDDIV=RESET_DIV.
  - FSM=IDLE, irq_empty=1, read_data follows the decode of the reset state.
- Push rule: a TXDATA write is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set at that edge.
  - Simultaneous push and pop leaves count unchanged.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop the head into the shift register, latch BAUDDIV into the bit timer, go to START.
  - START: tx=0 for one bit period, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first; shift right each bit period; after bit 7 go to STOP.
  - STOP: tx=1 for one bit period. Then, if FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.
- Bit period = max(latched BAUDDIV,1) clock cycles. A frame is exactly 10 bit periods.
- A BAUDDIV write mid-frame affects only the next frame (it is latched at the pop).
- Latency: a TXDATA write at edge E0 into an empty, idle block gives count=1 after E0. At E1 the FSM pops and tx drops to 0, held for one bit period.
- tx is driven from a register; it must not glitch.
- Reset mid-frame: at the next edge tx=1, FSM=IDLE, FIFO flushed, no partial frame resumes.
- The count field is wide enough for FIFO_DEPTH (4 bits for the default). Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- types_pkg gains:
  - register offset constants UART_TXDATA/UART_STATUS/UART_BAUD;
  - STATUS bit index constants;
  - enum uart_state_t {IDLE, START, DATA, STOP}.
- It reuses the existing ADDR_WIDTH and word_t.
- One sub-module, sync_fifo (parameterised WIDTH, DEPTH). It has push/pop/full/empty/count, the same clk and active-low synchronous reset, and show-ahead read data.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> tx=1; STATUS reads 0x002; BAUDDIV reads 434; irq_empty=1.
- Single byte: BAUDDIV=4, write 0x55 to TXDATA -> tx=0 from the next edge for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1 for 4 cycles. Total 40 cycles; afterwards irq_empty=1.
- Overflow: BAUDDIV=1000, write 10 bytes in 10 consecutive cycles -> the first pops immediately, 8 are queued, the 10th is dropped. STATUS reads count=8, full=1, overflow=1; writing STATUS=0x8 clears overflow.
- Back-to-back: BAUDDIV=2, write 0xA5 then 0x3C -> the second start bit begins on the cycle right after the first stop bit. Total 40 cycles with no idle gap.
- BAUDDIV change: write 0xFF at BAUDDIV=4, then BAUDDIV=8 during DATA -> the first frame keeps 4-cycle bits; a next byte is sent with 8-cycle bits.
- Reset mid-frame: reset=0 during DATA bit 3 with 3 bytes queued -> tx=1 next edge; after release STATUS reads empty; no further frames appear.
